// File: rtl/julia_pkg.sv
// Shared types and constants for the Julia renderer's frame path.
package julia_pkg;
    localparam int H_RES_DEF       = 640;
    localparam int V_RES_DEF       = 480;
    localparam int PIXEL_W         = 32;
    localparam int ADDR_W          = 32;
    localparam int BYTES_PER_PIXEL = 4;

    typedef logic [PIXEL_W-1:0] pixel_t;
    typedef logic [ADDR_W-1:0]  addr_t;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} frame_rd_state_t;
endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count; DEPTH must be a power of two.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_wr, do_rd;

    always_comb begin
        do_wr    = wr_en && (count_q != (AW+1)'(DEPTH));
        do_rd    = rd_en && (count_q != '0);
        wr_ptr_d = wr_ptr_q + AW'(do_wr);
        rd_ptr_d = rd_ptr_q + AW'(do_rd);
        count_d  = count_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;
    assign empty   = (count_q == '0);
endmodule

// File: rtl/frame_reader.sv
// Avalon-MM read master streaming one rendered frame in raster order to scan-out.
// FRAME_READER_CONTINUOUS_EN: when defined, frames are re-fetched back to back after one start.
module frame_reader
    import julia_pkg::*;
#(
    parameter int    H_RES      = H_RES_DEF,
    parameter int    V_RES      = V_RES_DEF,
    parameter addr_t BASE_ADDR  = 32'h0000_0000,
    parameter int    FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [31:0] rd_addr,
    output logic        rd_enable,
    input  logic        wait_request,
    input  logic [31:0] rd_data,
    input  logic        rd_data_valid,
    output logic [31:0] pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_sof,
    output logic        pix_eol,
    output logic        busy,
    output logic        frame_done
);
    localparam int          CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] TOTAL   = 32'(H_RES * V_RES);
    localparam logic [31:0] H_LAST  = 32'(H_RES - 1);
    localparam logic [31:0] V_LAST  = 32'(V_RES - 1);
    localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

    frame_rd_state_t state_q, state_d;
    addr_t           rd_addr_q, rd_addr_d;
    logic            rd_en_q, rd_en_d;
    logic [31:0]     acc_q, acc_d;
    logic [CW-1:0]   out_q, out_d;
    logic [31:0]     x_q, x_d, y_q, y_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [CW-1:0]   fifo_count;
    logic            fifo_empty;
    pixel_t          fifo_data;
    logic            accept, push, pop, last_pix;
    logic [CW:0]     fifo_next, credit_next;

    assign accept   = rd_en_q && !wait_request;
    assign push     = rd_data_valid && (out_q != '0);
    assign pop      = !fifo_empty && pix_ready;
    assign last_pix = busy_q && pop && (x_q == H_LAST) && (y_q == V_LAST);

    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        rd_en_d   = rd_en_q;
        acc_d     = acc_q;
        x_d       = x_q;
        y_d       = y_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        out_d     = out_q + CW'(accept) - CW'(push);
        if (accept) begin
            rd_addr_d = rd_addr_q + ADDR_W'(BYTES_PER_PIXEL);
            acc_d     = acc_q + 32'd1;
        end
        if (pop) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                y_d = y_q + 32'd1;
            end else begin
                x_d = x_q + 32'd1;
            end
        end
        // Credit looks at next-cycle occupancy so a request raised now always has a FIFO slot.
        fifo_next   = {1'b0, fifo_count} + (CW+1)'(push) - (CW+1)'(pop);
        credit_next = {1'b0, out_d} + fifo_next;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = FETCH;
                    rd_addr_d = BASE_ADDR;
                    rd_en_d   = 1'b1;
                    acc_d     = '0;
                    out_d     = '0;
                    x_d       = '0;
                    y_d       = '0;
                    busy_d    = 1'b1;
                end
            end
            FETCH: begin
                if (acc_d == TOTAL) begin
                    state_d = DRAIN;
                    rd_en_d = 1'b0;
                end else if (!(rd_en_q && wait_request)) begin
                    rd_en_d = (credit_next < DEPTH_W);
                end
            end
            DRAIN: begin
                if (last_pix) begin
                    state_d = DONE;
                    done_d  = 1'b1;
`ifdef FRAME_READER_CONTINUOUS_EN
                    busy_d  = 1'b1;
`else
                    busy_d  = 1'b0;
`endif
                end
            end
            DONE: begin
                x_d = '0;
                y_d = '0;
`ifdef FRAME_READER_CONTINUOUS_EN
                state_d   = FETCH;
                rd_addr_d = BASE_ADDR;
                rd_en_d   = 1'b1;
                acc_d     = '0;
`else
                state_d   = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rd_addr_q <= BASE_ADDR;
            rd_en_q   <= 1'b0;
            acc_q     <= '0;
            out_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            rd_en_q   <= rd_en_d;
            acc_q     <= acc_d;
            out_q     <= out_d;
            x_q       <= x_d;
            y_q       <= y_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    sync_fifo #(
        .WIDTH (PIXEL_W),
        .DEPTH (FIFO_DEPTH)
    ) u_pix_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data (rd_data),
        .rd_en   (pop),
        .rd_data (fifo_data),
        .count   (fifo_count),
        .empty   (fifo_empty)
    );

    assign rd_addr    = rd_addr_q;
    assign rd_enable  = rd_en_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign pix_valid  = !fifo_empty;
    assign pix_data   = fifo_data;
    assign pix_sof    = !fifo_empty && (x_q == '0) && (y_q == '0);
    assign pix_eol    = !fifo_empty && (x_q == H_LAST);
endmodule
